// File: rtl/apu_pkg.sv
// Shared APU constants, lookup tables and register payload types.
// Used by the pulse, noise and triangle channels.
package apu_pkg;

    localparam int unsigned TIMER_W = 11;
    localparam int unsigned SWEEP_W = 12;
    localparam int unsigned STEP_W  = 3;
    localparam int unsigned ENV_W   = 4;

    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // Bit n of each entry is the waveform level at sequencer step n.
    localparam logic [7:0] DUTY_TABLE [4] = '{
        8'b0000_0010,
        8'b0000_0110,
        8'b0001_1110,
        8'b1111_1001
    };

    typedef struct packed {
        logic [1:0]         duty;
        logic               halt;
        logic               constant;
        logic [ENV_W-1:0]   volume;
        logic               sweep_en;
        logic [2:0]         sweep_period;
        logic               negate;
        logic [2:0]         shift;
        logic [TIMER_W-1:0] period;
    } pulse_regs_t;

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: restarts at 15 on a start flag, then decays one step
// every (volume+1) quarter frames, optionally looping back to 15.
module apu_envelope
    import apu_pkg::*;
(
    input  logic             I_clock,
    input  logic             I_reset,
    input  logic             I_quarter,
    input  logic             I_start,
    input  logic             I_loop,
    input  logic [ENV_W-1:0] I_volume,
    output logic [ENV_W-1:0] O_decay
);

    logic [ENV_W-1:0] decay_q, decay_d;
    logic [ENV_W-1:0] divider_q, divider_d;

    always_comb begin
        decay_d   = decay_q;
        divider_d = divider_q;
        if (I_quarter) begin
            if (I_start) begin
                decay_d   = ENV_W'(15);
                divider_d = I_volume;
            end else if (divider_q == '0) begin
                divider_d = I_volume;
                if (decay_q != '0) begin
                    decay_d = decay_q - ENV_W'(1);
                end else if (I_loop) begin
                    decay_d = ENV_W'(15);
                end
            end else begin
                divider_d = divider_q - ENV_W'(1);
            end
        end
    end

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            decay_q   <= '0;
            divider_q <= '0;
        end else begin
            decay_q   <= decay_d;
            divider_q <= divider_d;
        end
    end

    assign O_decay = decay_q;

endmodule

// File: rtl/apu_pulse.sv
// Pulse (square-wave) channel: register decode, timer/sequencer, sweep,
// length counter and envelope, producing a registered 4-bit sample.
module apu_pulse
    import apu_pkg::*;
#(
    parameter int unsigned P_channel = 0
)
(
    input  logic       I_clock,
    input  logic       I_reset,
    input  logic       I_apu_tick,
    input  logic       I_quarter,
    input  logic       I_half,
    input  logic       I_enable,
    input  logic [1:0] I_host_addr,
    input  logic [7:0] I_host_data,
    input  logic       I_host_wren,
    output logic [3:0] O_sample,
    output logic       O_active
);

    // Pulse 1 negates in ones' complement, pulse 2 in two's complement.
    localparam logic [SWEEP_W-1:0] NEG_BORROW = (P_channel == 0) ? SWEEP_W'(1) : SWEEP_W'(0);

    pulse_regs_t        regs_q, regs_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [7:0]         length_q, length_d;
    logic               env_start_q, env_start_d;
    logic [2:0]         sweep_div_q, sweep_div_d;
    logic               sweep_reload_q, sweep_reload_d;
    logic [3:0]         sample_q, sample_d;
    logic               active_q, active_d;

    logic               wr0, wr1, wr2, wr3;
    logic [SWEEP_W-1:0] delta, target;
    logic               mute, sweep_hit, duty_bit;
    logic [ENV_W-1:0]   decay;

    assign wr0 = I_host_wren && (I_host_addr == 2'd0);
    assign wr1 = I_host_wren && (I_host_addr == 2'd1);
    assign wr2 = I_host_wren && (I_host_addr == 2'd2);
    assign wr3 = I_host_wren && (I_host_addr == 2'd3);

    // Sweep target and continuous mute evaluation.
    always_comb begin
        delta = SWEEP_W'(regs_q.period >> regs_q.shift);
        if (regs_q.negate) begin
            target = SWEEP_W'(regs_q.period) - delta - NEG_BORROW;
        end else begin
            target = SWEEP_W'(regs_q.period) + delta;
        end
        mute = (regs_q.period < TIMER_W'(8))
            || (!regs_q.negate && (target > SWEEP_W'(12'h7FF)));
        sweep_hit = I_half && (sweep_div_q == 3'd0) && regs_q.sweep_en
            && (regs_q.shift != 3'd0) && !mute;
    end

    always_comb begin
        regs_d         = regs_q;
        timer_d        = timer_q;
        step_d         = step_q;
        length_d       = length_q;
        env_start_d    = env_start_q;
        sweep_div_d    = sweep_div_q;
        sweep_reload_d = sweep_reload_q;

        // Strobe-driven updates first; host writes below override them.
        if (sweep_hit) begin
            regs_d.period = target[TIMER_W-1:0];
        end
        if (I_half) begin
            if ((sweep_div_q == 3'd0) || sweep_reload_q) begin
                sweep_div_d    = regs_q.sweep_period;
                sweep_reload_d = 1'b0;
            end else begin
                sweep_div_d = sweep_div_q - 3'd1;
            end
            if ((length_q != 8'd0) && !regs_q.halt) begin
                length_d = length_q - 8'd1;
            end
        end
        if (I_quarter) begin
            env_start_d = 1'b0;
        end
        if (I_apu_tick) begin
            if (timer_q == '0) begin
                timer_d = regs_q.period;
                step_d  = step_q + STEP_W'(1);
            end else begin
                timer_d = timer_q - TIMER_W'(1);
            end
        end

        if (wr0) begin
            {regs_d.duty, regs_d.halt, regs_d.constant, regs_d.volume} = I_host_data;
        end
        if (wr1) begin
            {regs_d.sweep_en, regs_d.sweep_period, regs_d.negate, regs_d.shift} = I_host_data;
            sweep_reload_d = 1'b1;
        end
        if (wr2) begin
            regs_d.period = {regs_q.period[10:8], I_host_data};
        end
        if (wr3) begin
            regs_d.period = {I_host_data[2:0], regs_q.period[7:0]};
            step_d        = '0;
            env_start_d   = 1'b1;
            length_d      = LENGTH_TABLE[I_host_data[7:3]];
        end
        if (!I_enable) begin
            length_d = 8'd0;
        end
    end

    always_comb begin
        duty_bit = DUTY_TABLE[regs_q.duty][step_q];
        sample_d = 4'd0;
        if ((length_q != 8'd0) && !mute && duty_bit) begin
            sample_d = regs_q.constant ? regs_q.volume : decay;
        end
        active_d = (length_q != 8'd0);
    end

    apu_envelope u_env (
        .I_clock   (I_clock),
        .I_reset   (I_reset),
        .I_quarter (I_quarter),
        .I_start   (env_start_q),
        .I_loop    (regs_q.halt),
        .I_volume  (regs_q.volume),
        .O_decay   (decay)
    );

    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            regs_q         <= '0;
            timer_q        <= '0;
            step_q         <= '0;
            length_q       <= '0;
            env_start_q    <= 1'b0;
            sweep_div_q    <= '0;
            sweep_reload_q <= 1'b0;
            sample_q       <= '0;
            active_q       <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            timer_q        <= timer_d;
            step_q         <= step_d;
            length_q       <= length_d;
            env_start_q    <= env_start_d;
            sweep_div_q    <= sweep_div_d;
            sweep_reload_q <= sweep_reload_d;
            sample_q       <= sample_d;
            active_q       <= active_d;
        end
    end

    assign O_sample = sample_q;
    assign O_active = active_q;

endmodule

// File: tb/tb_apu_pulse.sv
// Directed bench for apu_pulse: both channel variants driven in lockstep.
module tb_apu_pulse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       apu_tick, quarter, half, enable, host_wren;
    logic [1:0] host_addr;
    logic [7:0] host_data;
    logic [3:0] sample0, sample1;
    logic       active0, active1;

    int compared   = 0;
    int mismatched = 0;

    apu_pulse #(.P_channel(0)) dut0 (
        .I_clock(clk), .I_reset(rst_n), .I_apu_tick(apu_tick), .I_quarter(quarter),
        .I_half(half), .I_enable(enable), .I_host_addr(host_addr),
        .I_host_data(host_data), .I_host_wren(host_wren),
        .O_sample(sample0), .O_active(active0)
    );

    apu_pulse #(.P_channel(1)) dut1 (
        .I_clock(clk), .I_reset(rst_n), .I_apu_tick(apu_tick), .I_quarter(quarter),
        .I_half(half), .I_enable(enable), .I_host_addr(host_addr),
        .I_host_data(host_data), .I_host_wren(host_wren),
        .O_sample(sample1), .O_active(active1)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        host_addr = a;
        host_data = d;
        host_wren = 1'b1;
        step();
        host_wren = 1'b0;
    endtask

    task automatic pulse_half();
        half    = 1'b1;
        quarter = 1'b1;
        step();
        half    = 1'b0;
        quarter = 1'b0;
    endtask

    task automatic pulse_quarter();
        quarter = 1'b1;
        step();
        quarter = 1'b0;
        step();
    endtask

    initial begin
        logic [3:0] wave [8];
        int         idx;
        int         exp_decay;
        wave = '{4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};

        // Reset held with every strobe and a reg3 write active
        rst_n = 1'b0; apu_tick = 1'b1; quarter = 1'b1; half = 1'b1; enable = 1'b1;
        host_addr = 2'd3; host_data = 8'h08; host_wren = 1'b1;
        step();
        step();
        check("reset_sample", 16'(sample0), 16'd0);
        check("reset_active", 16'(active0), 16'd0);
        rst_n = 1'b1; apu_tick = 1'b0; quarter = 1'b0; half = 1'b0; host_wren = 1'b0;
        step();
        check("post_reset_active", 16'(active0), 16'd0);
        check("post_reset_sample1", 16'(sample1), 16'd0);

        // Waveform: duty 2, constant 15, period 8 -> 9 ticks per step
        wr(2'd0, 8'hBF);
        wr(2'd2, 8'h08);
        wr(2'd3, 8'h08);
        apu_tick = 1'b1;
        for (int n = 1; n <= 145; n++) begin
            step();
            if (n == 1) begin
                check("wave_active", 16'(active0), 16'd1);
                check("wave_first", 16'(sample0), 16'd0);
            end else begin
                idx = ((n - 2) / 9 + 1) % 8;
                check($sformatf("wave_n%0d", n), 16'(sample0), 16'(wave[idx]));
            end
        end
        apu_tick = 1'b0;

        // Length expiry with halt clear (duty 3 so step 0 is high)
        wr(2'd0, 8'hDF);
        wr(2'd3, 8'h00);
        repeat (9) pulse_half();
        step();
        check("len9_active", 16'(active0), 16'd1);
        check("len9_sample", 16'(sample0), 16'd15);
        pulse_half();
        step();
        check("len10_active", 16'(active0), 16'd0);
        check("len10_sample", 16'(sample0), 16'd0);

        // Same with halt set: length must not count down
        wr(2'd0, 8'hFF);
        wr(2'd3, 8'h00);
        repeat (10) pulse_half();
        step();
        check("halt_active", 16'(active0), 16'd1);
        check("halt_sample", 16'(sample0), 16'd15);

        // Envelope decay, period 2, no loop
        wr(2'd0, 8'hC2);
        wr(2'd3, 8'h08);
        for (int q = 1; q <= 50; q++) begin
            pulse_quarter();
            exp_decay = ((q - 1) / 3 >= 15) ? 0 : 15 - (q - 1) / 3;
            check($sformatf("env_q%0d", q), 16'(sample0), 16'(exp_decay));
        end

        // Envelope loop, period 0: wraps 0 -> 15
        wr(2'd0, 8'hE0);
        wr(2'd3, 8'h08);
        for (int k = 1; k <= 17; k++) begin
            pulse_quarter();
            exp_decay = (k == 17) ? 15 : 16 - k;
            check($sformatf("envloop_q%0d", k), 16'(sample0), 16'(exp_decay));
        end

        // Sweep negate: ones' vs two's complement
        wr(2'd2, 8'h00);
        wr(2'd3, 8'h09);
        wr(2'd1, 8'h89);
        check("sweep_pre_period", 16'(dut0.regs_q.period), 16'h100);
        pulse_half();
        check("sweep_p0_period", 16'(dut0.regs_q.period), 16'h07F);
        check("sweep_p1_period", 16'(dut1.regs_q.period), 16'h080);

        // Overflow mute, without any strobe
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h0F);
        step();
        check("ovf_pre_sample0", 16'(sample0), 16'd15);
        check("ovf_pre_sample1", 16'(sample1), 16'd15);
        wr(2'd1, 8'h81);
        step();
        check("ovf_mute_sample0", 16'(sample0), 16'd0);
        check("ovf_mute_sample1", 16'(sample1), 16'd0);
        check("ovf_active", 16'(active0), 16'd1);

        // Enable drop
        enable = 1'b0;
        step();
        check("endrop_edge_active", 16'(active0), 16'd1);
        step();
        check("endrop_active", 16'(active0), 16'd0);
        wr(2'd3, 8'h08);
        step();
        check("disabled_load_active", 16'(active0), 16'd0);
        enable = 1'b1;
        wr(2'd3, 8'h08);
        step();
        check("reenable_active", 16'(active1), 16'd1);
        check("reenable_sample", 16'(sample0), 16'd15);

        // Reset mid-note
        rst_n = 1'b0;
        step();
        check("midreset_sample", 16'(sample0), 16'd0);
        check("midreset_active", 16'(active0), 16'd0);
        rst_n = 1'b1;
        step();
        step();
        check("after_reset_active", 16'(active0), 16'd0);
        check("after_reset_sample", 16'(sample1), 16'd0);
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h08);
        wr(2'd3, 8'h08);
        step();
        check("restart_active", 16'(active0), 16'd1);
        check("restart_sample", 16'(sample0), 16'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/apu_pulse.md
# apu_pulse

Square-wave (pulse) tone generator for the audio path, two instances per design (P_channel 0 and 1). It decodes host writes to its four registers ($4000–$4003 or $4004–$4007) and produces a 4-bit sample per clock. The sample feeds the APU mixer, which drives the 16-bit input of audio_i2s. All timing derives from strobes supplied by the frame sequencer and the APU cycle divider.

## Interface
- P_channel, default 0: 0 selects pulse 1 (ones'-complement sweep negate); 1 selects pulse 2 (two's-complement).
- I_clock  in  1  system clock.
- I_reset  in  1  synchronous, active-low reset.
- I_apu_tick  in  1  one-cycle strobe, once every 2 CPU cycles.
- I_quarter  in  1  quarter-frame strobe from the frame sequencer.
- I_half  in  1  half-frame strobe; always coincides with an I_quarter.
- I_enable  in  1  channel enable bit from the $4015 write.
- I_host_addr  in  2  register index.
- I_host_data  in  8  write data.
- I_host_wren  in  1  write strobe, already qualified with chip select.
- O_sample  out  4  current output level, 0–15.
- O_active  out  1  length counter is non-zero; read back via $4015.

## Operation
- **Registers.**
  - reg0: duty[7:6], halt/loop[5], constant[4], volume/period[3:0].
  - reg1: sweep enable[7], period[6:4], negate[3], shift[2:0].
  - reg2: timer[7:0].
  - reg3: length index[7:3], timer[10:8].
- **Side effects of writes.**
  - Writing reg1 sets sweep_reload.
  - Writing reg3 resets the sequencer step to 0 and sets env_start.
  - Writing reg3 also loads the length counter from LENGTH_TABLE[index], but only if I_enable=1.
- **Timer.** 11-bit down counter. On each I_apu_tick:
  - if 0: reload from period and increment the 3-bit step, wrapping 7→0;
  - otherwise: decrement.
- **Duty patterns**, bit for step 0..7:
  - 0: 01000000
  - 1: 01100000
  - 2: 01111000
  - 3: 10011111
- **Envelope**, on I_quarter:
  - If env_start: clear env_start, set decay=15, set divider=volume.
  - Else if divider=0: set divider=volume, then decrement decay if non-zero; if decay is 0 and loop=1, reload it to 15.
  - Else: decrement divider.
- **Length counter**, on I_half: decrement if non-zero and halt=0. While I_enable=0 the length counter is held at 0.
- **Sweep target.** delta = period >> shift.
  - negate=0: target = period + delta, computed 12 bits wide.
  - negate=1: target = period − delta − (P_channel==0 ? 1 : 0).
- **Sweep mute.** Asserted when period < 8, or when negate=0 and target > 0x7FF. Mute is evaluated continuously, not only on strobes.
- **Sweep update**, on I_half:
  - If divider=0, enable=1, shift≠0 and not muted: period ← target[10:0].
  - Then, if divider=0 or sweep_reload: divider ← sweep period and clear sweep_reload; otherwise decrement divider.
- **Output.**
  - O_sample = 0 if length=0, or mute, or the duty bit is 0.
  - Otherwise O_sample = constant ? volume : decay.
  - O_active = (length≠0).

## Timing
- **Reset** (I_reset=0 at a clock edge): every register, counter and flag goes to 0. O_sample=0 and O_active=0 on the following cycle.
- **Registered outputs.** O_sample and O_active change one clock after the state change that causes them.
- **Write ordering.** A host write to reg3 in the same cycle as I_half, I_quarter or I_apu_tick takes priority.
  - The length load, step=0 and env_start all win over the strobe.
  - Timer counting continues unaffected.
- **Concurrent sweep write.** A reg2/reg3 write in the same cycle as a sweep period update: the host write wins.
- **Enable.** I_enable falling clears the length counter on that edge, so O_active=0 one cycle later.
- **Reset mid-note.** Reset during a note silences the channel immediately. The next write is required to restart it.
- **Timer period 0.** Legal. The step advances every tick, and the output is muted by the sweep rule.

## Structure
- **Package apu_pkg** holds:
  - LENGTH_TABLE: 32×8 entries; index 0→10, 1→254, 31→30, standard values throughout.
  - DUTY_TABLE: 4×8 entries.
  - a pulse_regs_t struct.
  - sweep and timer width constants.
  The noise and triangle channels share this package.
- **Sub-module apu_envelope** (I_clock, I_reset, I_quarter, I_start, I_loop, I_volume, O_decay) is reused by the noise channel.
- Sweep and length logic stay inline.

## Test plan
1. **Reset.** Assert I_reset=0 for 2 cycles with strobes active → O_sample=0, O_active=0.
2. **Waveform.** I_enable=1; write reg0=0xBF, reg2=0x08, reg3=0x08 → O_active=1. O_sample runs 0,15,15,15,15,0,0,0, each step lasting 9 I_apu_ticks, repeating.
3. **Length expiry.** Write reg0=0x9F (halt=0), reg3=0x00 (length 10); pulse I_half 10 times → O_active=0 and O_sample=0 after the 10th. Repeat with halt=1 → O_active stays 1.
4. **Envelope.** Write reg0=0x82 (decay, period 2), then reg3. The first I_quarter gives decay=15. Every 3 further quarters decay drops by 1 and holds at 0 with loop=0.
5. **Sweep.** P_channel=0; period=0x100, reg1=0x89 (enable, period 0, negate, shift 1); I_half → period=0x07F. P_channel=1, same stimulus → 0x080. Period 0x7FF with reg1=0x81 → O_sample=0 (overflow mute).
6. **Enable drop.** Drop I_enable mid-note → O_active=0 one cycle later. A reg3 write while I_enable=0 does not load length.
